decimal_to_binary_encoder: RTL and testbench
============================================

DECIMAL_TO_BINARY_ENCODER -- requirements
Module: decimal_to_binary_encoder

Interface
REQ-001 Parameter: PRIO_MSB, default 1, selects which set bit is encoded on multi-hot input: 1 = highest-index set bit, 0 = lowest-index set bit.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1, synchronous, active-high reset sampled on rising edge of clk.
REQ-004 Port: en, input, 1, sample enable; d_in is captured only on cycles where en=1.
REQ-005 Port: d_in, input, 10, decimal one-hot input; bit k asserted represents decimal digit k (0..9).
REQ-006 Port: d_out, output, 4, registered binary code of the selected digit.
REQ-007 Port: valid, output, 1, registered; high for one cycle after each enabled capture.
REQ-008 Port: zero, output, 1, registered; high when the captured d_in was all zeros.
REQ-009 Port: multi, output, 1, registered; high when the captured d_in had two or more bits set.

Function
REQ-010 The block SHALL be fully synchronous: d_out, valid, zero and multi are flops; no combinational path from d_in to any output.
REQ-011 Latency SHALL be exactly 1 clock: values presented with en=1 at edge N appear on outputs after edge N.
REQ-012 For exactly one bit d_in[k] set, d_out SHALL equal k as unsigned 4-bit binary (k=0 -> 0000 ... k=9 -> 1001), with zero=0 and multi=0.
REQ-013 For d_in=0000000000, d_out SHALL be 0000, zero=1, multi=0.
REQ-014 For two or more bits set, multi SHALL be 1, zero=0, and d_out SHALL be the index of the highest set bit when PRIO_MSB=1, the lowest set bit when PRIO_MSB=0.
REQ-015 d_out SHALL never exceed 1001; codes 1010-1111 are unreachable.
REQ-016 When en=0 at a rising edge, d_out, zero and multi SHALL hold their previous values, and valid SHALL be 0 after that edge.
REQ-017 When en=1 at a rising edge, valid SHALL be 1 after that edge, regardless of d_in content, including zero or multi-hot inputs.
REQ-018 Back-to-back en=1 cycles SHALL produce one new result per cycle with no bubbles.
REQ-019 zero and multi SHALL never both be 1 in the same cycle.
REQ-020 X/Z on d_in while en=0 SHALL NOT affect any output.

Reset
REQ-021 With rst=1 at a rising edge, d_out SHALL become 0000, and valid, zero and multi SHALL become 0.
REQ-022 rst SHALL take priority over en: with rst=1 and en=1 at the same edge, the reset values are loaded and d_in is discarded.
REQ-023 Asserting rst mid-stream SHALL discard the pending capture.
REQ-024 The first enabled capture after rst deasserts SHALL behave per REQ-011..REQ-014.
REQ-025 No output SHALL change on any edge other than a rising edge of clk, including on rst assertion between edges.

Verification
REQ-026 Reset then walk: rst=1 for 2 cycles, then en=1 with d_in = 0, 1, 2, 4, 8, 16, 32, 64, 128, 256, 512 on consecutive cycles -> one cycle later d_out = 0000, then 0000, 0001, 0010, ..., 1001; zero=1 only for the first result; valid=1 throughout; multi=0.
REQ-027 Multi-hot: d_in=1000000101, en=1 -> multi=1, zero=0, d_out=1001 (PRIO_MSB=1) or d_out=0000 (PRIO_MSB=0).
REQ-028 Hold: capture d_in=0000100000 (d_out=0101), then en=0 with d_in=1000000000 for 3 cycles -> d_out stays 0101 and valid=0.
REQ-029 Reset priority: d_out=1001 registered, then rst=1 and en=1 with d_in=0000000100 at the same edge -> d_out=0000, valid=0, zero=0, multi=0.
REQ-030 Exhaustive: all 1024 d_in values with en=1 -> d_out, zero and multi match a reference model one cycle later; d_out is never above 1001.

Source files
------------

// File: rtl/decimal_to_binary_encoder.sv
// Registered 10-to-4 decimal priority encoder with zero / multi-hot flags.
// PRIO_MSB selects whether the highest (1) or lowest (0) set bit wins on multi-hot input.
module decimal_to_binary_encoder #(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] d_in,
  output logic [3:0] d_out,
  output logic       valid,
  output logic       zero,
  output logic       multi
);

  logic [3:0] sel;
  logic       zero_c;
  logic       multi_c;

  // Later loop iterations overwrite earlier ones, so scan order sets the priority.
  always_comb begin
    sel = 4'd0;
    if (PRIO_MSB) begin
      for (int i = 0; i < 10; i++) begin
        if (d_in[i]) sel = 4'(i);
      end
    end else begin
      for (int i = 9; i >= 0; i--) begin
        if (d_in[i]) sel = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign zero_c  = ~|d_in;
  assign multi_c = |(d_in & (d_in - 10'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= 4'd0;
      valid <= 1'b0;
      zero  <= 1'b0;
      multi <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        d_out <= sel;
        zero  <= zero_c;
        multi <= multi_c;
      end
    end
  end

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Scoreboard bench: driver pushes model expectations each cycle, monitor pops and compares.
// Two DUT instances cover both priority settings from the same stimulus.
module tb_decimal_to_binary_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] d_in;
  logic [3:0] d_out_hi, d_out_lo;
  logic       valid_hi, valid_lo, zero_hi, zero_lo, multi_hi, multi_lo;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] dout_hi;
    logic [3:0] dout_lo;
    logic       valid;
    logic       zero;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_hi, m_lo;
  logic       m_valid, m_zero, m_multi;

  always #5 clk = ~clk;

  decimal_to_binary_encoder #(.PRIO_MSB(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in),
    .d_out(d_out_hi), .valid(valid_hi), .zero(zero_hi), .multi(multi_hi)
  );

  decimal_to_binary_encoder #(.PRIO_MSB(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in),
    .d_out(d_out_lo), .valid(valid_lo), .zero(zero_lo), .multi(multi_lo)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: highest index = floor(log2 v); lowest index = log2 of the isolated lowest bit.
  task automatic model(input logic r, input logic e, input logic [9:0] d);
    int v, low_bit;
    if (r) begin
      m_hi = 0; m_lo = 0; m_valid = 0; m_zero = 0; m_multi = 0;
    end else if (e) begin
      v = int'(d);
      m_valid = 1;
      m_zero  = (v == 0);
      m_multi = ($countones(d) >= 2);
      if (v == 0) begin
        m_hi = 0; m_lo = 0;
      end else begin
        low_bit = v & (-v);
        m_hi = 4'($clog2(v + 1) - 1);
        m_lo = 4'($clog2(low_bit));
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [9:0] d);
    exp_t x;
    rst = r; en = e; d_in = d;
    @(posedge clk);
    model(r, e, d);
    x.dout_hi = m_hi; x.dout_lo = m_lo;
    x.valid = m_valid; x.zero = m_zero; x.multi = m_multi;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("valid_hi", {3'b0, valid_hi}, {3'b0, x.valid});
      chk("valid_lo", {3'b0, valid_lo}, {3'b0, x.valid});
      chk("d_out_hi", d_out_hi, x.dout_hi);
      chk("d_out_lo", d_out_lo, x.dout_lo);
      chk("zero_hi",  {3'b0, zero_hi},  {3'b0, x.zero});
      chk("zero_lo",  {3'b0, zero_lo},  {3'b0, x.zero});
      chk("multi_hi", {3'b0, multi_hi}, {3'b0, x.multi});
      chk("multi_lo", {3'b0, multi_lo}, {3'b0, x.multi});
      n_cmp++;
      if (d_out_hi > 4'd9 || d_out_lo > 4'd9) begin
        n_bad++;
        $display("FAIL d_out_range: got %0d/%0d expected <= 9", d_out_hi, d_out_lo);
      end
      n_cmp++;
      if ((zero_hi && multi_hi) || (zero_lo && multi_lo)) begin
        n_bad++;
        $display("FAIL zero_multi_excl: zero and multi both 1");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] r;
    rst = 1'b1; en = 1'b0; d_in = '0;
    @(negedge clk);

    // reset then walking one-hot
    step(1, 0, '0);
    step(1, 0, '0);
    step(0, 1, 10'd0);
    for (int k = 0; k < 10; k++) step(0, 1, 10'(1 << k));

    // multi-hot
    step(0, 1, 10'b1000000101);

    // hold with en=0
    step(0, 1, 10'b0000100000);
    repeat (3) step(0, 0, 10'b1000000000);

    // reset priority over en
    step(0, 1, 10'b1000000000);
    step(1, 1, 10'b0000000100);
    step(0, 1, 10'b0000000100);

    // X on d_in while disabled
    step(0, 0, 'x);
    step(0, 0, 'x);

    // exhaustive
    for (int v = 0; v < 1024; v++) step(0, 1, 10'(v));

    // randomized en / rst / data
    for (int i = 0; i < 600; i++) begin
      r = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0: r = 10'(1 << $urandom_range(0, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        step(($urandom_range(0, 19) == 0), 0, 'x);
      else
        step(($urandom_range(0, 19) == 0), 1, r);
    end

    step(0, 0, '0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
